ipa_gcm_bank_arbiter: RTL and testbench

- Shares the two global context memory (GCM) SRAM banks between two requester classes:
  - the IPA context-fetch engine, which reads 64 bits across both banks atomically;
  - the DMA-side TCDM crossbar, which issues per-bank 32-bit accesses.
- Replaces simple OR-merging with per-bank arbitration under a selectable policy, starvation bounding, test-and-set lock protection, and one-cycle read-response routing back to the winning requester.
- Sits between the crossbar/context controller and the SRAM bank master ports.

---
 rtl/ipa_gcm_bank_arbiter.sv | 127 ++++++++++++
 tb/tb_ipa_gcm_bank_arbiter.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ipa_gcm_bank_arbiter.sv
// Per-bank arbiter sharing the two GCM SRAM banks between the atomic 64-bit context
// fetch and the per-bank TCDM crossbar, with lock protection and response routing.
module ipa_gcm_bank_arbiter #(
  parameter int unsigned ADDR_MEM_WIDTH = 12,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned BE_WIDTH       = 4,
  parameter int unsigned ID_WIDTH       = 20,
  parameter int unsigned MAX_WAIT       = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [1:0]                  policy_i,
  input  logic                        ctx_req_i,
  input  logic [ADDR_MEM_WIDTH-1:0]   ctx_addr_i,
  output logic                        ctx_gnt_o,
  output logic                        ctx_rvalid_o,
  output logic [2*DATA_WIDTH-1:0]     ctx_rdata_o,
  input  logic [1:0]                  xb_req_i,
  input  logic [2*ADDR_MEM_WIDTH-1:0] xb_add_i,
  input  logic [1:0]                  xb_wen_i,
  input  logic [2*DATA_WIDTH-1:0]     xb_wdata_i,
  input  logic [2*BE_WIDTH-1:0]       xb_be_i,
  input  logic [2*ID_WIDTH-1:0]       xb_id_i,
  input  logic [1:0]                  xb_ts_set_i,
  output logic [1:0]                  xb_gnt_o,
  output logic [1:0]                  xb_rvalid_o,
  output logic [2*DATA_WIDTH-1:0]     xb_rdata_o,
  output logic [2*ID_WIDTH-1:0]       xb_rid_o,
  output logic [1:0]                  sram_req_o,
  output logic [2*ADDR_MEM_WIDTH-1:0] sram_add_o,
  output logic [1:0]                  sram_wen_o,
  output logic [2*DATA_WIDTH-1:0]     sram_wdata_o,
  output logic [2*BE_WIDTH-1:0]       sram_be_o,
  input  logic [2*DATA_WIDTH-1:0]     sram_rdata_i,
  output logic                        busy_o
);

  typedef enum logic [1:0] {OWN_NONE, OWN_CTX, OWN_XB} owner_t;

  localparam logic [7:0] WAIT_MAX = 8'(MAX_WAIT);

  logic [1:0]          ts_q;
  logic [1:0]          lock;
  logic                rr_q;
  logic [7:0]          ctx_wait;
  logic [7:0]          xb_wait [2];
  owner_t              owner_q [2];
  logic [ID_WIDTH-1:0] id_q    [2];
  logic [1:0]          xb_sat;
  logic                contended;
  logic                ctx_win;

  assign lock      = xb_ts_set_i | ts_q;
  assign xb_sat    = {xb_wait[1] == WAIT_MAX, xb_wait[0] == WAIT_MAX};
  assign contended = ctx_req_i & (lock == '0) & (xb_req_i != '0);

  // The context claims both banks or nothing; the crossbar takes whatever it leaves.
  always_comb begin
    ctx_win = 1'b0;
    if (ctx_req_i && lock == '0) begin
      if (xb_req_i == '0)              ctx_win = 1'b1;
      else if (ctx_wait == WAIT_MAX)   ctx_win = 1'b1;
      else if (xb_sat != '0)           ctx_win = 1'b0;
      else begin
        unique case (policy_i)
          2'b00:   ctx_win = 1'b1;
          2'b01:   ctx_win = 1'b0;
          default: ctx_win = ~rr_q;
        endcase
      end
    end
  end

  assign ctx_gnt_o = ctx_win;
  assign xb_gnt_o  = xb_req_i & {2{~ctx_win}};

  for (genvar b = 0; b < 2; b++) begin : g_bank
    assign sram_req_o[b] = ctx_win | xb_gnt_o[b];
    assign sram_add_o[b*ADDR_MEM_WIDTH +: ADDR_MEM_WIDTH] =
      ctx_win ? ctx_addr_i : xb_add_i[b*ADDR_MEM_WIDTH +: ADDR_MEM_WIDTH];
    assign sram_wen_o[b] = ctx_win ? 1'b1 : xb_wen_i[b];
    assign sram_wdata_o[b*DATA_WIDTH +: DATA_WIDTH] =
      ctx_win ? '0 : xb_wdata_i[b*DATA_WIDTH +: DATA_WIDTH];
    assign sram_be_o[b*BE_WIDTH +: BE_WIDTH] =
      ctx_win ? '1 : xb_be_i[b*BE_WIDTH +: BE_WIDTH];
    assign xb_rvalid_o[b]                       = (owner_q[b] == OWN_XB);
    assign xb_rid_o[b*ID_WIDTH +: ID_WIDTH]     = id_q[b];
  end

  assign xb_rdata_o   = sram_rdata_i;
  assign ctx_rvalid_o = (owner_q[0] == OWN_CTX);
  assign ctx_rdata_o  = {sram_rdata_i[DATA_WIDTH-1:0], sram_rdata_i[2*DATA_WIDTH-1:DATA_WIDTH]};
  assign busy_o       = ctx_req_i | (xb_req_i != '0) |
                        (owner_q[0] != OWN_NONE) | (owner_q[1] != OWN_NONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts_q     <= '0;
      rr_q     <= 1'b0;
      ctx_wait <= '0;
      for (int unsigned b = 0; b < 2; b++) begin
        xb_wait[b] <= '0;
        owner_q[b] <= OWN_NONE;
        id_q[b]    <= '0;
      end
    end else begin
      ts_q <= xb_ts_set_i;
      if (contended && policy_i[1]) rr_q <= ~rr_q;
      if (ctx_req_i && !ctx_win)
        ctx_wait <= (ctx_wait == WAIT_MAX) ? ctx_wait : ctx_wait + 8'd1;
      else
        ctx_wait <= '0;
      for (int unsigned b = 0; b < 2; b++) begin
        if (xb_req_i[b] && !xb_gnt_o[b])
          xb_wait[b] <= (xb_wait[b] == WAIT_MAX) ? xb_wait[b] : xb_wait[b] + 8'd1;
        else
          xb_wait[b] <= '0;
        // A test-and-set second phase is granted but never answered.
        if (ctx_win)                               owner_q[b] <= OWN_CTX;
        else if (xb_gnt_o[b] && !xb_ts_set_i[b])   owner_q[b] <= OWN_XB;
        else                                       owner_q[b] <= OWN_NONE;
        if (xb_gnt_o[b]) id_q[b] <= xb_id_i[b*ID_WIDTH +: ID_WIDTH];
      end
    end
  end

endmodule

// File: tb/tb_ipa_gcm_bank_arbiter.sv
// Randomized scoreboard bench for ipa_gcm_bank_arbiter with an SRAM model and
// a rule-level reference arbiter.
module tb_ipa_gcm_bank_arbiter;
  localparam int AW = 12, DW = 32, BW = 4, IW = 20, MAXW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0] policy_i = '0;
  logic ctx_req_i = 1'b0;
  logic [AW-1:0] ctx_addr_i = '0;
  logic ctx_gnt_o, ctx_rvalid_o;
  logic [2*DW-1:0] ctx_rdata_o;
  logic [1:0] xb_req_i = '0, xb_wen_i = '1, xb_ts_set_i = '0;
  logic [2*AW-1:0] xb_add_i = '0;
  logic [2*DW-1:0] xb_wdata_i = '0;
  logic [2*BW-1:0] xb_be_i = '0;
  logic [2*IW-1:0] xb_id_i = '0;
  logic [1:0] xb_gnt_o, xb_rvalid_o, sram_req_o, sram_wen_o;
  logic [2*DW-1:0] xb_rdata_o, sram_wdata_o, sram_rdata_i;
  logic [2*IW-1:0] xb_rid_o;
  logic [2*AW-1:0] sram_add_o;
  logic [2*BW-1:0] sram_be_o;
  logic busy_o;

  always #5 clk = ~clk;

  ipa_gcm_bank_arbiter #(.ADDR_MEM_WIDTH(AW), .DATA_WIDTH(DW), .BE_WIDTH(BW),
                         .ID_WIDTH(IW), .MAX_WAIT(MAXW)) dut (
    .clk(clk), .rst_n(rst_n), .policy_i(policy_i),
    .ctx_req_i(ctx_req_i), .ctx_addr_i(ctx_addr_i), .ctx_gnt_o(ctx_gnt_o),
    .ctx_rvalid_o(ctx_rvalid_o), .ctx_rdata_o(ctx_rdata_o),
    .xb_req_i(xb_req_i), .xb_add_i(xb_add_i), .xb_wen_i(xb_wen_i), .xb_wdata_i(xb_wdata_i),
    .xb_be_i(xb_be_i), .xb_id_i(xb_id_i), .xb_ts_set_i(xb_ts_set_i), .xb_gnt_o(xb_gnt_o),
    .xb_rvalid_o(xb_rvalid_o), .xb_rdata_o(xb_rdata_o), .xb_rid_o(xb_rid_o),
    .sram_req_o(sram_req_o), .sram_add_o(sram_add_o), .sram_wen_o(sram_wen_o),
    .sram_wdata_o(sram_wdata_o), .sram_be_o(sram_be_o), .sram_rdata_i(sram_rdata_i),
    .busy_o(busy_o)
  );

  // Bench SRAM: read-before-write, data one cycle after request.
  logic [31:0] mem [2][4096];
  logic [31:0] ref_mem [2][4096];
  logic [31:0] rd [2];
  assign sram_rdata_i = {rd[1], rd[0]};
  always @(posedge clk) begin
    for (int b = 0; b < 2; b++) begin
      if (sram_req_o[b]) begin
        rd[b] <= mem[b][sram_add_o[b*AW +: AW]];
        if (!sram_wen_o[b])
          for (int k = 0; k < 4; k++)
            if (sram_be_o[b*BW + k])
              mem[b][sram_add_o[b*AW +: AW]][8*k +: 8] <= sram_wdata_o[b*DW + 8*k +: 8];
      end
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0, n_fail = 0;
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  typedef struct {
    int          due;
    bit          cv;
    logic [63:0] cd;
    bit [1:0]    xv;
    logic [63:0] xd;
    logic [39:0] xid;
  } resp_t;
  resp_t q[$];

  // Reference state
  int cw = 0;
  int xw [2] = '{0, 0};
  bit rr = 0, outst = 0;
  bit [1:0] tsp = '0;
  bit g_ctx = 0;
  bit [1:0] g_xb = '0;

  task automatic eval();
    bit eg, lk;
    bit [1:0] xg, xv, ts;
    resp_t r;
    @(negedge clk);
    ts = xb_ts_set_i;
    lk = (ts != 0) || (tsp != 0);
    eg = 0;
    if (ctx_req_i && !lk) begin
      if (xb_req_i == 0) eg = 1;
      else begin
        if (cw == MAXW) eg = 1;
        else if (xw[0] == MAXW || xw[1] == MAXW) eg = 0;
        else if (policy_i == 2'b00) eg = 1;
        else if (policy_i == 2'b01) eg = 0;
        else eg = !rr;
        if (policy_i[1]) rr = !rr;
      end
    end
    xg = eg ? 2'b00 : xb_req_i;
    check("ctx_gnt", ctx_gnt_o, eg);
    check("xb_gnt", xb_gnt_o, xg);
    check("sram_req", sram_req_o, {eg | xg[1], eg | xg[0]});
    check("busy", busy_o, ctx_req_i || xb_req_i != 0 || outst);
    for (int b = 0; b < 2; b++) if (eg || xg[b]) begin
      check("sram_add", sram_add_o[b*AW +: AW], eg ? ctx_addr_i : xb_add_i[b*AW +: AW]);
      check("sram_wen", sram_wen_o[b], eg ? 1'b1 : xb_wen_i[b]);
      check("sram_wdata", sram_wdata_o[b*DW +: DW], eg ? 32'h0 : xb_wdata_i[b*DW +: DW]);
      check("sram_be", sram_be_o[b*BW +: BW], eg ? 4'hF : xb_be_i[b*BW +: BW]);
    end
    xv = xg & ~ts;
    if (eg || xv != 0) begin
      r.due = cyc + 1;
      r.cv  = eg;
      r.xv  = xv;
      r.cd  = {ref_mem[0][ctx_addr_i], ref_mem[1][ctx_addr_i]};
      for (int b = 0; b < 2; b++) begin
        r.xd[b*32 +: 32]  = ref_mem[b][xb_add_i[b*AW +: AW]];
        r.xid[b*IW +: IW] = xb_id_i[b*IW +: IW];
      end
      q.push_back(r);
    end
    for (int b = 0; b < 2; b++)
      if (xg[b] && !xb_wen_i[b])
        for (int k = 0; k < 4; k++)
          if (xb_be_i[b*BW + k])
            ref_mem[b][xb_add_i[b*AW +: AW]][8*k +: 8] = xb_wdata_i[b*DW + 8*k +: 8];
    cw = (ctx_req_i && !eg) ? ((cw < MAXW) ? cw + 1 : cw) : 0;
    for (int b = 0; b < 2; b++)
      xw[b] = (xb_req_i[b] && !xg[b]) ? ((xw[b] < MAXW) ? xw[b] + 1 : xw[b]) : 0;
    tsp   = ts;
    outst = eg || xv != 0;
    g_ctx = eg;
    g_xb  = xg;
  endtask

  // Monitor: pops an expectation whenever the DUT presents a response.
  initial begin
    resp_t r;
    forever begin
      @(posedge clk); #3;
      if (ctx_rvalid_o || xb_rvalid_o != 0) begin
        if (q.size() == 0) check("resp_spurious", {ctx_rvalid_o, xb_rvalid_o}, 3'b000);
        else begin
          r = q.pop_front();
          check("resp_cycle", cyc, r.due);
          check("ctx_rvalid", ctx_rvalid_o, r.cv);
          check("xb_rvalid", xb_rvalid_o, r.xv);
          if (r.cv) check("ctx_rdata", ctx_rdata_o, r.cd);
          for (int b = 0; b < 2; b++) if (r.xv[b]) begin
            check("xb_rdata", xb_rdata_o[b*DW +: DW], r.xd[b*32 +: 32]);
            check("xb_rid", xb_rid_o[b*IW +: IW], r.xid[b*IW +: IW]);
          end
        end
      end else if (q.size() > 0 && q[0].due <= cyc) begin
        r = q.pop_front();
        check("resp_missing", {ctx_rvalid_o, xb_rvalid_o}, {r.cv, r.xv});
      end
    end
  end

  task automatic clear_inputs();
    ctx_req_i = 0; xb_req_i = '0; xb_ts_set_i = '0; xb_wen_i = '1;
  endtask

  // New request only where the previous one was granted or absent.
  task automatic drive_next(input int ctx_pct, input bit [1:0] mask, input int xb_pct, input int ts_pct);
    if (!ctx_req_i || g_ctx) begin
      ctx_req_i  = ($urandom_range(99) < ctx_pct);
      ctx_addr_i = AW'($urandom_range(15));
    end
    for (int b = 0; b < 2; b++) if (!xb_req_i[b] || g_xb[b]) begin
      xb_req_i[b]              = mask[b] && ($urandom_range(99) < xb_pct);
      xb_add_i[b*AW +: AW]     = AW'($urandom_range(15));
      xb_wen_i[b]              = 1'($urandom_range(1));
      xb_wdata_i[b*DW +: DW]   = $urandom;
      xb_be_i[b*BW +: BW]      = BW'($urandom_range(15));
      xb_id_i[b*IW +: IW]      = IW'($urandom);
      xb_ts_set_i[b]           = xb_req_i[b] && ($urandom_range(99) < ts_pct);
    end
  endtask

  task automatic run(input logic [1:0] pol, input int n, input int ctx_pct,
                     input bit [1:0] mask, input int xb_pct, input int ts_pct);
    policy_i = pol;
    for (int i = 0; i < n; i++) begin
      drive_next(ctx_pct, mask, xb_pct, ts_pct);
      eval();
      @(posedge clk); #1;
    end
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 0;
    q.delete();
    cw = 0; xw = '{0, 0}; rr = 0; tsp = '0; outst = 0; g_ctx = 0; g_xb = '0;
    @(negedge clk);
    check("rst_ctx_gnt", ctx_gnt_o, 1'b0);
    check("rst_xb_gnt", xb_gnt_o, 2'b00);
    check("rst_ctx_rvalid", ctx_rvalid_o, 1'b0);
    check("rst_xb_rvalid", xb_rvalid_o, 2'b00);
    check("rst_sram_req", sram_req_o, 2'b00);
    check("rst_busy", busy_o, 1'b0);
    check("rst_xb_rid", xb_rid_o, '0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1;
  endtask

  initial begin
    bit [2:0] gseq;
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < 4096; i++) begin
        mem[b][i] = $urandom;
        ref_mem[b][i] = mem[b][i];
      end
    #1;
    do_reset();

    // Fixed priority with full contention: forced crossbar win after MAX_WAIT stalls.
    run(2'b00, 24, 100, 2'b11, 100, 0);

    // Context read at 0x010.
    clear_inputs();
    mem[0][16] = 32'hAAAA_0001; ref_mem[0][16] = 32'hAAAA_0001;
    mem[1][16] = 32'hBBBB_0002; ref_mem[1][16] = 32'hBBBB_0002;
    ctx_req_i = 1; ctx_addr_i = 12'h010;
    eval();
    check("ctx010_sram_add", sram_add_o, {12'h010, 12'h010});
    @(posedge clk); #1;
    ctx_req_i = 0;
    #2;
    check("ctx010_rvalid", ctx_rvalid_o, 1'b1);
    check("ctx010_rdata", ctx_rdata_o, 64'hAAAA0001_BBBB0002);
    eval();
    @(posedge clk); #1;

    // Crossbar priority, single-bank crossbar: atomic context must wait.
    run(2'b01, 12, 100, 2'b01, 100, 0);
    // Round-robin after a fresh reset starts with the context.
    do_reset();
    run(2'b10, 16, 100, 2'b11, 100, 0);

    // Test-and-set pulse on bank 1 blocks the context for two cycles.
    clear_inputs();
    eval(); @(posedge clk); #1;
    policy_i = 2'b00;
    ctx_req_i = 1; ctx_addr_i = 12'h005;
    xb_req_i = 2'b10; xb_ts_set_i = 2'b10; xb_wen_i = 2'b11;
    xb_id_i[IW +: IW] = 20'h5A5A5;
    eval(); gseq[0] = ctx_gnt_o;
    @(posedge clk); #1;
    xb_req_i = '0; xb_ts_set_i = '0;
    eval(); gseq[1] = ctx_gnt_o;
    @(posedge clk); #1;
    eval(); gseq[2] = ctx_gnt_o;
    check("ts_ctx_gnt_seq", gseq, 3'b100);
    @(posedge clk); #1;
    ctx_req_i = 0;

    // Reset right after a grant drops the outstanding response.
    run(2'b11, 6, 100, 2'b11, 100, 0);
    do_reset();
    eval();
    check("post_reset_busy", busy_o, 1'b0);
    @(posedge clk); #1;

    for (int p = 0; p < 4; p++) run(2'(p), 300, 50, 2'b11, 60, 10);

    clear_inputs();
    for (int i = 0; i < 3; i++) begin
      eval(); @(posedge clk); #1;
    end
    if (q.size() != 0) check("queue_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
